fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 9 +
 rtl/fetch_stage_if_id_register.sv | 43 ++++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch constants: NOP encoding and default reset PC / PC step,
// used by fetch, decode and the bench.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          PC_STEP_DEF  = 4;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: valid/instr/pc/pc_four with load, squash and hold.
// Single-cycle; priority reset > squash > load > hold.
module if_id_register
   import fetch_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load_i,
   input  logic        squash_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_four_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_four_o
);

   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic [31:0] pc_four_q;

   always_ff @(posedge clock) begin
      if (reset || squash_i) begin
         valid_q   <= 1'b0;
         instr_q   <= NOP_INSTR;
         pc_q      <= 32'h0;
         pc_four_q <= 32'h0;
      end else if (load_i) begin
         valid_q   <= 1'b1;
         instr_q   <= instr_i;
         pc_q      <= pc_i;
         pc_four_q <= pc_four_i;
      end
   end

   assign valid_o   = valid_q;
   assign instr_o   = instr_q;
   assign pc_o      = pc_q;
   assign pc_four_o = pc_four_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect/stall priority, IF/ID capture,
// sticky misaligned-redirect flag and saturating fetch counter.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          PC_STEP  = PC_STEP_DEF,
   parameter int          COUNT_W  = 16
) (
   input  logic               clock,
   input  logic               reset,
   output logic [31:0]        imem_addr,
   input  logic [31:0]        imem_data,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               id_valid,
   output logic [31:0]        id_instr,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_pc_four,
   output logic               align_err,
   output logic [COUNT_W-1:0] fetch_count
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   logic [31:0]        pc_q, pc_d;
   logic [31:0]        pc_next_seq;
   logic               align_q, align_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               load;

   assign pc_next_seq = pc_q + STEP;
   assign load        = !redirect && !stall;

   always_comb begin
      pc_d    = pc_q;
      align_d = align_q;
      count_d = count_q;
      if (redirect) begin
         pc_d = {redirect_pc[31:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00)
            align_d = 1'b1;
      end else if (!stall) begin
         pc_d = pc_next_seq;
         if (count_q != {COUNT_W{1'b1}})
            count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         align_q <= 1'b0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         align_q <= align_d;
         count_q <= count_d;
      end
   end

   if_id_register u_if_id (
      .clock     (clock),
      .reset     (reset),
      .load_i    (load),
      .squash_i  (redirect),
      .instr_i   (imem_data),
      .pc_i      (pc_q),
      .pc_four_i (pc_next_seq),
      .valid_o   (id_valid),
      .instr_o   (id_instr),
      .pc_o      (id_pc),
      .pc_four_o (id_pc_four)
   );

   assign imem_addr   = pc_q;
   assign align_err   = align_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default instance for the main flow and a
// second instance near the top of the address space with a 2-bit counter.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clock = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        reset_a, stall_a, redirect_a;
   logic [31:0] redirect_pc_a, imem_addr_a, imem_data_a;
   logic        id_valid_a, align_err_a;
   logic [31:0] id_instr_a, id_pc_a, id_pc_four_a;
   logic [15:0] fetch_count_a;

   logic        reset_b, stall_b, redirect_b;
   logic [31:0] redirect_pc_b, imem_addr_b, imem_data_b;
   logic        id_valid_b, align_err_b;
   logic [31:0] id_instr_b, id_pc_b, id_pc_four_b;
   logic [1:0]  fetch_count_b;

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h8C01_0004;
         32'h0000_0004: mem_word = 32'h0022_1820;
         32'h0000_0008: mem_word = 32'hAC03_0008;
         default:       mem_word = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   always_comb imem_data_a = mem_word(imem_addr_a);
   always_comb imem_data_b = mem_word(imem_addr_b);

   fetch_stage dut_a (
      .clock(clock), .reset(reset_a), .imem_addr(imem_addr_a), .imem_data(imem_data_a),
      .stall(stall_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
      .id_valid(id_valid_a), .id_instr(id_instr_a), .id_pc(id_pc_a),
      .id_pc_four(id_pc_four_a), .align_err(align_err_a), .fetch_count(fetch_count_a)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4), .COUNT_W(2)) dut_b (
      .clock(clock), .reset(reset_b), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
      .stall(stall_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
      .id_valid(id_valid_b), .id_instr(id_instr_b), .id_pc(id_pc_b),
      .id_pc_four(id_pc_four_b), .align_err(align_err_b), .fetch_count(fetch_count_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [31:0] addr, input logic vld,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic [15:0] cnt);
      chk({tag, ".imem_addr"},   imem_addr_a,   addr);
      chk({tag, ".id_valid"},    32'(id_valid_a), 32'(vld));
      chk({tag, ".id_instr"},    id_instr_a,    instr);
      chk({tag, ".id_pc"},       id_pc_a,       pc);
      chk({tag, ".id_pc_four"},  id_pc_four_a,  pc4);
      chk({tag, ".fetch_count"}, 32'(fetch_count_a), 32'(cnt));
   endtask

   initial begin
      reset_a = 1'b1; stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = 32'h0;
      reset_b = 1'b1; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'h0;
      step(); step();
      chk_a("rst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 16'd0);
      chk("rst.align_err", 32'(align_err_a), 32'h0);

      // Free-running fetch
      reset_a = 1'b0;
      step(); chk_a("run1", 32'h4, 1'b1, 32'h8C01_0004, 32'h0, 32'h4, 16'd1);
      step(); chk_a("run2", 32'h8, 1'b1, 32'h0022_1820, 32'h4, 32'h8, 16'd2);
      step(); chk_a("run3", 32'hC, 1'b1, 32'hAC03_0008, 32'h8, 32'hC, 16'd3);

      // Stall holds everything
      stall_a = 1'b1;
      step(); chk_a("stall1", 32'hC, 1'b1, 32'hAC03_0008, 32'h8, 32'hC, 16'd3);
      step(); chk_a("stall2", 32'hC, 1'b1, 32'hAC03_0008, 32'h8, 32'hC, 16'd3);
      stall_a = 1'b0;
      step(); chk_a("unstall", 32'h10, 1'b1, 32'hA5A5_000C, 32'hC, 32'h10, 16'd4);

      // Redirect wins over stall
      stall_a = 1'b1; redirect_a = 1'b1; redirect_pc_a = 32'h40;
      step(); chk_a("redir", 32'h40, 1'b0, NOP_INSTR, 32'h0, 32'h0, 16'd4);
      stall_a = 1'b0; redirect_a = 1'b0;
      step(); chk_a("post_redir", 32'h44, 1'b1, 32'hA5A5_0040, 32'h40, 32'h44, 16'd5);
      chk("post_redir.align_err", 32'(align_err_a), 32'h0);

      // Redirect to current pc, then back-to-back misaligned redirect
      redirect_a = 1'b1; redirect_pc_a = 32'h44;
      step(); chk_a("redir_self", 32'h44, 1'b0, NOP_INSTR, 32'h0, 32'h0, 16'd5);
      chk("redir_self.align_err", 32'(align_err_a), 32'h0);
      redirect_pc_a = 32'h46;
      step(); chk_a("redir_mis", 32'h44, 1'b0, NOP_INSTR, 32'h0, 32'h0, 16'd5);
      redirect_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("align_sticky%0d", i), 32'(align_err_a), 32'h1);
         step();
      end
      chk_a("after_mis", 32'h58, 1'b1, 32'hA5A5_0054, 32'h54, 32'h58, 16'd10);
      chk("after_mis.align_err", 32'(align_err_a), 32'h1);

      // Reset overrides a simultaneous redirect and stall
      reset_a = 1'b1; redirect_a = 1'b1; stall_a = 1'b1; redirect_pc_a = 32'h100;
      step(); chk_a("rst_mid", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 16'd0);
      chk("rst_mid.align_err", 32'(align_err_a), 32'h0);
      reset_a = 1'b0; redirect_a = 1'b0; stall_a = 1'b0;

      // PC wrap and counter saturation on the second instance
      reset_b = 1'b0;
      chk("wrap0.imem_addr", imem_addr_b, 32'hFFFF_FFF8);
      step();
      chk("wrap1.imem_addr", imem_addr_b, 32'hFFFF_FFFC);
      chk("wrap1.id_pc", id_pc_b, 32'hFFFF_FFF8);
      chk("wrap1.id_pc_four", id_pc_four_b, 32'hFFFF_FFFC);
      chk("wrap1.id_instr", id_instr_b, 32'h5A5A_FFF8);
      step();
      chk("wrap2.imem_addr", imem_addr_b, 32'h0);
      chk("wrap2.id_pc", id_pc_b, 32'hFFFF_FFFC);
      chk("wrap2.id_pc_four", id_pc_four_b, 32'h0);
      chk("wrap2.fetch_count", 32'(fetch_count_b), 32'd2);
      step();
      chk("wrap3.id_instr", id_instr_b, 32'h8C01_0004);
      chk("wrap3.fetch_count", 32'(fetch_count_b), 32'd3);
      step();
      chk("sat.fetch_count", 32'(fetch_count_b), 32'd3);
      chk("sat.imem_addr", imem_addr_b, 32'h8);
      chk("sat.id_valid", 32'(id_valid_b), 32'h1);
      chk("sat.align_err", 32'(align_err_b), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
